// File: rtl/rf_wb_arbiter_if.sv
// Bus between the write-back producers, the arbiter and the register-file write port.
// The master side drives producer requests; the slave side (the arbiter) drives rf/pending.
interface rf_wb_arbiter_if #(
  parameter int unsigned PTR_W = 2
);
  logic              pipe_we;
  logic [4:0]        pipe_addr;
  logic [31:0]       pipe_data;
  logic [31:0]       pipe_pc;
  logic              md_valid;
  logic              md_ready;
  logic [4:0]        md_addr;
  logic [31:0]       md_data;
  logic [31:0]       md_pc;
  logic              rf_we;
  logic [4:0]        rf_addr;
  logic [31:0]       rf_data;
  logic [31:0]       rf_pc;
  logic [31:0]       pending;
  logic [PTR_W:0]    q_count;

  modport master (
    output pipe_we, pipe_addr, pipe_data, pipe_pc,
    output md_valid, md_addr, md_data, md_pc,
    input  md_ready, rf_we, rf_addr, rf_data, rf_pc, pending, q_count
  );

  modport slave (
    input  pipe_we, pipe_addr, pipe_data, pipe_pc,
    input  md_valid, md_addr, md_data, md_pc,
    output md_ready, rf_we, rf_addr, rf_data, rf_pc, pending, q_count
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: pipeline writes take priority, long-latency results
// queue in a small FIFO with WAW squash, and a pending mask tracks queued destinations.
module rf_wb_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  rf_wb_arbiter_if.slave bus
);
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = PTR_W + 1;

  typedef struct packed {
    logic          live;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] pc;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]      count_q, count_d;
  logic               rf_we_q, rf_we_d;
  logic [AW-1:0]      rf_addr_q, rf_addr_d;
  logic [DW-1:0]      rf_data_q, rf_data_d;
  logic [DW-1:0]      rf_pc_q, rf_pc_d;

  logic               md_ready_c, pipe_fire_c, push_c, pop_c;
  logic [31:0]        pending_c;

  assign md_ready_c  = rst && (count_q != CW'(DEPTH));
  assign pipe_fire_c = bus.pipe_we && (bus.pipe_addr != '0);
  assign push_c      = bus.md_valid && md_ready_c && (bus.md_addr != '0);
  assign pop_c       = !pipe_fire_c && (count_q != '0);

  // Next state: pipeline wins the port, else the FIFO head drains; squash applies after push.
  always_comb begin
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    rf_we_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    rf_pc_d   = rf_pc_q;
    if (pipe_fire_c) begin
      rf_we_d   = 1'b1;
      rf_addr_d = bus.pipe_addr;
      rf_data_d = bus.pipe_data;
      rf_pc_d   = bus.pipe_pc;
    end else if (pop_c) begin
      rf_we_d               = mem_q[head_q].live;
      rf_addr_d             = mem_q[head_q].addr;
      rf_data_d             = mem_q[head_q].data;
      rf_pc_d               = mem_q[head_q].pc;
      mem_d[head_q].live    = 1'b0;
      head_d                = head_q + PTR_W'(1);
    end
    if (push_c) begin
      mem_d[tail_q] = '{live: 1'b1, addr: bus.md_addr, data: bus.md_data, pc: bus.md_pc};
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pipe_fire_c) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (mem_d[PTR_W'(i)].addr == bus.pipe_addr) mem_d[PTR_W'(i)].live = 1'b0;
      end
    end
    count_d = count_q + CW'(push_c) - CW'(pop_c);
  end

  // Popped and reset slots have live cleared, so live alone means "stored and not squashed".
  always_comb begin
    pending_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (mem_q[PTR_W'(i)].live) pending_c[mem_q[PTR_W'(i)].addr] = 1'b1;
    end
    pending_c[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[PTR_W'(i)] <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      rf_pc_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[PTR_W'(i)] <= mem_d[PTR_W'(i)];
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      rf_we_q   <= rf_we_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      rf_pc_q   <= rf_pc_d;
    end
  end

  assign bus.md_ready = md_ready_c;
  assign bus.rf_we    = rf_we_q;
  assign bus.rf_addr  = rf_addr_q;
  assign bus.rf_data  = rf_data_q;
  assign bus.rf_pc    = rf_pc_q;
  assign bus.pending  = pending_c;
  assign bus.q_count  = count_q;
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter that owns the single write port of `rf`. It merges two result producers into one registered `write_enable`/`write_addr`/`write_data`/`curr_pc` stream. The producers are the in-order pipeline write-back (always accepted) and a long-latency unit (mul/div) with a valid/ready handshake buffered in a small FIFO. It exports a per-register pending mask so the hazard unit can stall readers of registers whose long-latency result has not yet been written.

## Interface
- `DEPTH`, 4: FIFO entries for long-latency results; power of two, 2..16.
- `PTR_W`, 2: log2(DEPTH).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous assert, active-low (0 = reset).
- `pipe_we` input 1: pipeline write-back request this cycle.
- `pipe_addr` input 5: pipeline destination register.
- `pipe_data` input 32: pipeline result.
- `pipe_pc` input 32: PC of the producing instruction.
- `md_valid` input 1: long-latency result offered.
- `md_ready` output 1: FIFO can accept; transfer when `md_valid & md_ready` at a rising edge.
- `md_addr` input 5; `md_data` input 32; `md_pc` input 32: long-latency result fields.
- `rf_we` output 1: to `rf.write_enable`.
- `rf_addr` output 5: to `rf.write_addr`.
- `rf_data` output 32: to `rf.write_data`.
- `rf_pc` output 32: to `rf.curr_pc`.
- `pending` output 32: bit i = 1 while a live FIFO entry targets register i; bit 0 is constantly 0.
- `q_count` output PTR_W+1: live plus squashed entries currently stored.

## Operation
- FIFO: circular buffer, head/tail pointers PTR_W bits wrapping modulo DEPTH, count PTR_W+1 bits. Each entry holds {live, addr, data, pc}.
- Push: on a handshake with `md_addr != 0`, write the entry with live=1 at the tail, tail+1, count+1. A handshake with `md_addr == 0` completes but stores nothing.
- `md_ready = rst & (count != DEPTH)`. It uses the current count only. A pop in the same cycle does not free a slot early.
- Arbitration per edge, registered into the `rf_*` outputs. Priority order:
  1. `pipe_we & pipe_addr != 0`: output {1, pipe_addr, pipe_data, pipe_pc}. The FIFO does not pop.
  2. Else, FIFO non-empty: pop the head. Output {head.live, head.addr, head.data, head.pc}. A squashed head gives `rf_we = 0` but is still consumed.
  3. Else: `rf_we = 0`. `rf_addr`, `rf_data` and `rf_pc` hold their previous values.
- `pipe_we` with `pipe_addr == 0` is treated as no request, so the FIFO may drain that cycle.
- WAW squash: when rule 1 fires, every stored entry with addr == pipe_addr gets live cleared at the same edge. This includes an entry pushed at that same edge. The newer pipeline write wins. Squashed entries no longer contribute to `pending`.
- `pending`: OR over stored live entries of one-hot(addr). Combinational from registered FIFO state only.
- Simultaneous push and pop: both happen, and count is unchanged. Push into an empty FIFO together with an idle output: the entry is stored, and the earliest pop is the next edge (no bypass).

## Timing
- Reset (`rst` = 0, asynchronous) clears the following immediately:
  - `rf_we`, `rf_addr`, `rf_data`, `rf_pc`, head, tail, count and all live bits go to 0.
  - `pending` becomes 0 and `md_ready` becomes 0.
  - After release, `md_ready` is 1 on the first cycle.
- Reset mid-operation discards all queued results and any handshake in that cycle. No `rf_we` pulse is produced.
- Pipeline latency: request sampled at edge E, `rf_we = 1` during cycle E..E+1, and `rf` commits at edge E+1.
- Long-latency minimum latency: handshake at edge E, pop at E+1, `rf` commit at E+2. Each cycle of pipeline priority adds one cycle.
- `pending[i]` rises in the cycle after the push edge. It falls in the cycle after the edge that pops or squashes the entry.
- Starvation: the FIFO drains only in cycles without a pipeline write. The hazard unit must stall on `pending` to guarantee drain.

## Test plan
- Reset then idle: `rf_we = 0`, `pending = 0`, `md_ready = 1`, `q_count = 0`. Assert `rst` = 0 with 3 entries queued: all outputs return to 0 asynchronously.
- Single md result {addr 5, data 0x1234, pc 0x3000} with no pipe writes: `pending[5] = 1` for one cycle. Then `rf_we = 1`, `rf_addr = 5`, `rf_data = 0x1234`, `rf_pc = 0x3000` one edge after the push, and `pending` returns to 0.
- Fill to DEPTH with `pipe_we` held high (addr 3, distinct from queued addrs 8..11): `md_ready = 0` at count 4, only pipe writes appear on `rf_*`. Drop `pipe_we`: entries 8, 9, 10, 11 appear in order, one per cycle.
- WAW: queue addr 7 data 0xAAAA, then pipe write addr 7 data 0xBBBB. Required: pipe write emitted, `pending[7]` clears, and the later pop of the squashed entry gives `rf_we = 0`. The last value written to 7 is 0xBBBB.
- Zero register: md handshake with addr 0 completes with count unchanged. Pipe write with addr 0 while one entry is queued causes that entry to pop in the same cycle.
- Simultaneous push/pop at count 2: count stays 2, order preserved. Also run DEPTH+3 pushes/pops to cover pointer wrap.
